csi2_rx_global_operation: RTL and testbench
===========================================

Name: csi2_rx_global_operation

Overview:
- Receive-side counterpart of the CSI-2 TX global operation block; sits between the D-PHY receiver (DCI wrapper) and the RX packet header/footer parser.
- Tracks the data-lane-0 LP line state to detect the HS request sequence (LP-11 -> LP-01 -> LP-00) and enables HS termination.
- Waits a settle interval, then searches for the 0xB8 leader (sync) byte on all active lanes.
- Packs the aligned HS bytes into a 4-lane packet word, and ends the burst when LP-11 returns.

Parameters:
- DATA_WIDTH, 8, bits per lane per core_clk; only 8 is supported.
- NUM_LANES, 4, active HS data lanes; legal values 1..4.
- LP_FILTER_CYC, 2, cycles an LP state must be stable before it is accepted.
- TSETTLE_CYC, 6, cycles after accepted LP-00 before sync search starts.
- SYNC_TIMEOUT_CYC, 16, maximum sync-search cycles before an SoT error.

Ports:
- core_clk  in  1  single block clock.
- reset  in  1  synchronous, active-high reset.
- lp_data_p_i  in  1  lane-0 LP Dp level, already synchronised to core_clk.
- lp_data_n_i  in  1  lane-0 LP Dn level, already synchronised to core_clk.
- hs_data_i  in  NUM_LANES*DATA_WIDTH  HS bytes; lane 0 in the LSBs.
- hs_term_en_o  out  1  enables HS receiver termination.
- dphy_pkten_o  out  1  dphy_pkt_o holds valid burst data this cycle.
- dphy_pkt_o  out  4*DATA_WIDTH  lane bytes, lane0 in [7:0]; lanes >= NUM_LANES driven 0.
- sot_err_o  out  1  one-cycle pulse on SoT/sync failure.
- burst_end_o  out  1  one-cycle pulse when an HS burst terminates normally.

Behaviour:
- Reset: every output is 0, the FSM is in IDLE, and all counters are 0. Reset mid-burst aborts the burst immediately, with no burst_end_o or sot_err_o pulse.
- LP filter:
  - The raw {p,n} state must be identical for LP_FILTER_CYC consecutive cycles to become lp_st.
  - lp_st keeps its previous value until then.
  - lp_st resets to LP-11.
- FSM states: IDLE, HS_RQST, HS_PREP, SYNC, HS_DATA, WAIT_LP11.
- IDLE: lp_st==LP-01 -> HS_RQST. Any other state stays in IDLE.
- HS_RQST:
  - lp_st==LP-00 -> HS_PREP, and the settle counter loads 0.
  - lp_st==LP-11 -> IDLE (aborted request, no error).
  - lp_st==LP-10 -> WAIT_LP11 with sot_err_o pulse.
- HS_PREP:
  - hs_term_en_o=1 from the cycle HS_PREP is entered.
  - The settle counter increments each cycle; when it reaches TSETTLE_CYC-1 -> SYNC.
  - lp_st==LP-11 -> IDLE with sot_err_o.
- SYNC:
  - hs_term_en_o=1; the timeout counter increments each cycle.
  - Sync found when every active lane byte == 0xB8 in the same cycle -> HS_DATA. The sync byte is not forwarded.
  - Only a subset of lanes == 0xB8 -> WAIT_LP11 with sot_err_o (lane skew is not supported).
  - Counter reaches SYNC_TIMEOUT_CYC-1 without sync -> WAIT_LP11 with sot_err_o.
  - lp_st==LP-11 -> IDLE with sot_err_o.
  - Sync and timeout in the same cycle: sync wins.
- HS_DATA:
  - hs_term_en_o=1.
  - Every cycle, dphy_pkten_o=1 and dphy_pkt_o is registered from hs_data_i, giving 1-cycle latency.
  - The first valid word is the cycle after the sync cycle.
  - lp_st==LP-11 -> IDLE: dphy_pkten_o=0 in the cycle the state leaves, burst_end_o pulses once, hs_term_en_o drops.
  - Trail bytes are forwarded unmodified; the packet layer discards them.
- WAIT_LP11: all outputs 0 except the error pulse; lp_st==LP-11 -> IDLE.
- dphy_pkt_o holds its last value while dphy_pkten_o=0; it is not cleared.
- Only one of sot_err_o and burst_end_o pulses per burst.
- Counter widths are clog2 of the respective parameter, with a minimum of 1 bit.

Decomposition:
- Shared package csi2_rx_pkg:
  - LP state encodings: LP11=2'b11, LP01=2'b01, LP00=2'b00, LP10=2'b10.
  - FSM state enum.
  - SYNC_BYTE=8'hB8.
  - Default timing constants.
- One natural sub-module, csi2_rx_lp_filter: stability filter producing lp_st, reused for the clock lane later.

Test Plan:
- Nominal 2-lane burst (NUM_LANES=2):
  - Stimulus: LP11x4, LP01x3, LP00x3, 6 settle cycles, lanes {B8,B8}, then words {11,22},{33,44}, then LP11.
  - Required: dphy_pkten_o high for exactly 2 cycles with dphy_pkt_o=32'h0000_2211 then 32'h0000_4433; burst_end_o pulses once; hs_term_en_o is high from HS_PREP entry until the state leaves HS_DATA.
- Glitch rejection: single-cycle LP01 inside LP11 -> FSM stays IDLE, no outputs change.
- Aborted request: LP01 held 3 cycles, then back to LP11 -> returns to IDLE, no sot_err_o, hs_term_en_o stays 0.
- Sync timeout: valid request, but lanes stay 8'h00 for 16 SYNC cycles -> sot_err_o pulses once; no dphy_pkten_o until LP11 plus a fresh request.
- Partial sync (NUM_LANES=4): lanes {B8,B8,B8,00} -> sot_err_o pulses, FSM goes to WAIT_LP11; the next full request with all lanes B8 then succeeds.
- Reset mid-burst: assert reset during HS_DATA -> the next cycle all outputs are 0 and there is no burst_end_o pulse; after release, a fresh request is handled normally.

Source files
------------

// File: rtl/csi2_rx_pkg.sv
// rtl/csi2_rx_pkg.sv - shared LP encodings, FSM states and timing defaults for the CSI-2 RX front end
package csi2_rx_pkg;

    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP00 = 2'b00;
    localparam logic [1:0] LP10 = 2'b10;

    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    localparam int DEF_DATA_WIDTH       = 8;
    localparam int DEF_NUM_LANES        = 4;
    localparam int DEF_LP_FILTER_CYC    = 2;
    localparam int DEF_TSETTLE_CYC      = 6;
    localparam int DEF_SYNC_TIMEOUT_CYC = 16;

    typedef enum logic [2:0] {
        IDLE,
        HS_RQST,
        HS_PREP,
        SYNC,
        HS_DATA,
        WAIT_LP11
    } rx_state_e;

    // Counter width for a terminal count of n: clog2(n), never narrower than 1 bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/csi2_rx_lp_filter.sv
// rtl/csi2_rx_lp_filter.sv - LP line stability filter; a {p,n} level is accepted only after
// FILTER_CYC identical consecutive samples, otherwise the previous accepted state is held.
module csi2_rx_lp_filter
    import csi2_rx_pkg::*;
#(
    parameter int FILTER_CYC = DEF_LP_FILTER_CYC
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] lp_raw_i,
    output logic [1:0] lp_st_o
);

    localparam int CW = cnt_w(FILTER_CYC);
    localparam logic [CW-1:0] STABLE = CW'(FILTER_CYC - 1);

    logic [1:0]    cand_q, cand_d;
    logic [1:0]    st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // cnt counts repeats of the candidate beyond its first sample, saturating at STABLE.
    always_comb begin
        cand_d = lp_raw_i;
        cnt_d  = '0;
        st_d   = st_q;
        if (lp_raw_i == cand_q) begin
            cnt_d = (cnt_q == STABLE) ? cnt_q : cnt_q + CW'(1);
        end
        if (cnt_d == STABLE) begin
            st_d = lp_raw_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cand_q <= LP11;
            cnt_q  <= '0;
            st_q   <= LP11;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            st_q   <= st_d;
        end
    end

    assign lp_st_o = st_q;

endmodule

// File: rtl/csi2_rx_global_operation.sv
// rtl/csi2_rx_global_operation.sv - CSI-2 RX global operation: LP request detection, HS settle,
// leader-byte sync search and packing of aligned HS bytes into a 4-lane packet word.
module csi2_rx_global_operation
    import csi2_rx_pkg::*;
#(
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int NUM_LANES        = DEF_NUM_LANES,
    parameter int LP_FILTER_CYC    = DEF_LP_FILTER_CYC,
    parameter int TSETTLE_CYC      = DEF_TSETTLE_CYC,
    parameter int SYNC_TIMEOUT_CYC = DEF_SYNC_TIMEOUT_CYC
) (
    input  logic                            core_clk,
    input  logic                            reset,
    input  logic                            lp_data_p_i,
    input  logic                            lp_data_n_i,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] hs_data_i,
    output logic                            hs_term_en_o,
    output logic                            dphy_pkten_o,
    output logic [4*DATA_WIDTH-1:0]         dphy_pkt_o,
    output logic                            sot_err_o,
    output logic                            burst_end_o
);

    localparam int SW = cnt_w(TSETTLE_CYC);
    localparam int TW = cnt_w(SYNC_TIMEOUT_CYC);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(TSETTLE_CYC - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(SYNC_TIMEOUT_CYC - 1);

    logic [1:0]              lp_st;
    rx_state_e               state_q, state_d;
    logic [SW-1:0]           settle_q, settle_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic                    all_sync, any_sync;
    logic                    err_evt, end_evt, capture;
    logic [4*DATA_WIDTH-1:0] pkt_q, pkt_d;
    logic                    pkten_q, pkten_d;
    logic                    err_q, err_d;
    logic                    bend_q, bend_d;

    csi2_rx_lp_filter #(
        .FILTER_CYC (LP_FILTER_CYC)
    ) u_lp_filter (
        .clk_i    (core_clk),
        .rst_i    (reset),
        .lp_raw_i ({lp_data_p_i, lp_data_n_i}),
        .lp_st_o  (lp_st)
    );

    always_comb begin
        all_sync = 1'b1;
        any_sync = 1'b0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (hs_data_i[l*DATA_WIDTH +: DATA_WIDTH] == SYNC_BYTE) begin
                any_sync = 1'b1;
            end else begin
                all_sync = 1'b0;
            end
        end
    end

    always_ff @(posedge core_clk) begin
        if (reset) begin
            state_q  <= IDLE;
            settle_q <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            tmo_q    <= tmo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        tmo_d    = tmo_q;
        err_evt  = 1'b0;
        end_evt  = 1'b0;
        capture  = 1'b0;
        case (state_q)
            IDLE: begin
                if (lp_st == LP01) state_d = HS_RQST;
            end
            HS_RQST: begin
                if (lp_st == LP00) begin
                    state_d  = HS_PREP;
                    settle_d = '0;
                end else if (lp_st == LP11) begin
                    state_d = IDLE;
                end else if (lp_st == LP10) begin
                    state_d = WAIT_LP11;
                    err_evt = 1'b1;
                end
            end
            HS_PREP: begin
                if (lp_st == LP11) begin
                    state_d = IDLE;
                    err_evt = 1'b1;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d = SYNC;
                    tmo_d   = '0;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            SYNC: begin
                // A full match beats the timeout; a partial match means lane skew, which is fatal.
                if (lp_st == LP11) begin
                    state_d = IDLE;
                    err_evt = 1'b1;
                end else if (all_sync) begin
                    state_d = HS_DATA;
                end else if (any_sync || (tmo_q == TMO_LAST)) begin
                    state_d = WAIT_LP11;
                    err_evt = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            HS_DATA: begin
                if (lp_st == LP11) begin
                    state_d = IDLE;
                    end_evt = 1'b1;
                end else begin
                    capture = 1'b1;
                end
            end
            WAIT_LP11: begin
                if (lp_st == LP11) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hs_term_en_o = (state_q == HS_PREP) || (state_q == SYNC) || (state_q == HS_DATA);
        pkten_d      = capture;
        err_d        = err_evt;
        bend_d       = end_evt;
        pkt_d        = pkt_q;
        if (capture) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                pkt_d[l*DATA_WIDTH +: DATA_WIDTH] = hs_data_i[l*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // The packet word is not cleared between bursts; lanes above NUM_LANES stay at their reset 0.
    always_ff @(posedge core_clk) begin
        if (reset) begin
            pkt_q   <= '0;
            pkten_q <= 1'b0;
            err_q   <= 1'b0;
            bend_q  <= 1'b0;
        end else begin
            pkt_q   <= pkt_d;
            pkten_q <= pkten_d;
            err_q   <= err_d;
            bend_q  <= bend_d;
        end
    end

    assign dphy_pkten_o = pkten_q;
    assign dphy_pkt_o   = pkt_q;
    assign sot_err_o    = err_q;
    assign burst_end_o  = bend_q;

endmodule

// File: tb/tb_csi2_rx_global_operation.sv
// tb/tb_csi2_rx_global_operation.sv - bench for csi2_rx_global_operation with 2-lane and 4-lane instances
module tb_csi2_rx_global_operation;

    localparam int TSETTLE = 6;
    localparam int TMO     = 16;
    localparam int FILT    = 2;
    localparam bit [1:0] L11 = 2'b11, L01 = 2'b01, L00 = 2'b00, L10 = 2'b10;

    logic        core_clk = 1'b0;
    logic        reset    = 1'b1;
    logic        lp_p     = 1'b1;
    logic        lp_n     = 1'b1;
    logic [31:0] hs       = '0;

    logic        term2, pkten2, err2, bend2;
    logic [31:0] pkt2;
    logic        term4, pkten4, err4, bend4;
    logic [31:0] pkt4;

    always #5 core_clk = ~core_clk;

    csi2_rx_global_operation #(.NUM_LANES(2)) dut2 (
        .core_clk     (core_clk),
        .reset        (reset),
        .lp_data_p_i  (lp_p),
        .lp_data_n_i  (lp_n),
        .hs_data_i    (hs[15:0]),
        .hs_term_en_o (term2),
        .dphy_pkten_o (pkten2),
        .dphy_pkt_o   (pkt2),
        .sot_err_o    (err2),
        .burst_end_o  (bend2)
    );

    csi2_rx_global_operation #(.NUM_LANES(4)) dut4 (
        .core_clk     (core_clk),
        .reset        (reset),
        .lp_data_p_i  (lp_p),
        .lp_data_n_i  (lp_n),
        .hs_data_i    (hs),
        .hs_term_en_o (term4),
        .dphy_pkten_o (pkten4),
        .dphy_pkt_o   (pkt4),
        .sot_err_o    (err4),
        .burst_end_o  (bend4)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: phase plus elapsed cycles in that phase, one per instance; shared LP window.
    typedef enum int {M_IDLE, M_RQST, M_PREP, M_SYNC, M_DATA, M_WAIT} mph_t;
    mph_t        ph[2];
    int          age[2];
    bit   [1:0]  acc = 2'b11;
    bit   [1:0]  hist[$];
    bit          e_term[2], e_pkten[2], e_err[2], e_bend[2];
    logic [31:0] e_pkt[2];
    bit          mvalid = 1'b0;
    int          n_term[2], n_pkten[2], n_err[2], n_bend[2];

    task automatic model_step(input bit rst, input bit [1:0] raw, input logic [31:0] d);
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                ph[i] = M_IDLE; age[i] = 0;
                e_term[i] = 0; e_pkten[i] = 0; e_err[i] = 0; e_bend[i] = 0; e_pkt[i] = '0;
            end
            acc = L11;
            hist.delete();
            mvalid = 1'b1;
            return;
        end
        for (int i = 0; i < 2; i++) begin
            int          nl;
            int          hits;
            mph_t        nx;
            logic [31:0] mask;
            nl   = (i == 0) ? 2 : 4;
            mask = (i == 0) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
            hits = 0;
            nx   = ph[i];
            for (int l = 0; l < nl; l++) if (d[8*l +: 8] == 8'hB8) hits++;
            e_err[i] = 0; e_bend[i] = 0; e_pkten[i] = 0;
            case (ph[i])
                M_IDLE: if (acc == L01) nx = M_RQST;
                M_RQST: begin
                    if (acc == L00) nx = M_PREP;
                    else if (acc == L11) nx = M_IDLE;
                    else if (acc == L10) begin nx = M_WAIT; e_err[i] = 1; end
                end
                M_PREP: begin
                    if (acc == L11) begin nx = M_IDLE; e_err[i] = 1; end
                    else if (age[i] + 1 == TSETTLE) nx = M_SYNC;
                end
                M_SYNC: begin
                    if (acc == L11) begin nx = M_IDLE; e_err[i] = 1; end
                    else if (hits == nl) nx = M_DATA;
                    else if (hits > 0 || age[i] + 1 == TMO) begin nx = M_WAIT; e_err[i] = 1; end
                end
                M_DATA: begin
                    if (acc == L11) begin nx = M_IDLE; e_bend[i] = 1; end
                    else begin e_pkten[i] = 1; e_pkt[i] = d & mask; end
                end
                default: if (acc == L11) nx = M_IDLE;
            endcase
            age[i]    = (nx == ph[i]) ? age[i] + 1 : 0;
            ph[i]     = nx;
            e_term[i] = (nx == M_PREP) || (nx == M_SYNC) || (nx == M_DATA);
        end
        hist.push_back(raw);
        if (hist.size() > FILT) void'(hist.pop_front());
        if (hist.size() == FILT) begin
            bit same;
            same = 1'b1;
            foreach (hist[k]) if (hist[k] != raw) same = 1'b0;
            if (same) acc = raw;
        end
    endtask

    task automatic model_check;
        if (!mvalid) return;
        checks++;
        if ({term2, pkten2, err2, bend2, pkt2} !== {e_term[0], e_pkten[0], e_err[0], e_bend[0], e_pkt[0]}) begin
            errors++;
            $display("FAIL model_lanes2 t=%0t got term/en/err/end/pkt=%b%b%b%b/%h exp=%b%b%b%b/%h", $time,
                     term2, pkten2, err2, bend2, pkt2, e_term[0], e_pkten[0], e_err[0], e_bend[0], e_pkt[0]);
        end
        checks++;
        if ({term4, pkten4, err4, bend4, pkt4} !== {e_term[1], e_pkten[1], e_err[1], e_bend[1], e_pkt[1]}) begin
            errors++;
            $display("FAIL model_lanes4 t=%0t got term/en/err/end/pkt=%b%b%b%b/%h exp=%b%b%b%b/%h", $time,
                     term4, pkten4, err4, bend4, pkt4, e_term[1], e_pkten[1], e_err[1], e_bend[1], e_pkt[1]);
        end
    endtask

    task automatic tally;
        n_term[0] += int'(term2);  n_pkten[0] += int'(pkten2); n_err[0] += int'(err2); n_bend[0] += int'(bend2);
        n_term[1] += int'(term4);  n_pkten[1] += int'(pkten4); n_err[1] += int'(err4); n_bend[1] += int'(bend4);
    endtask

    task automatic clear_tally;
        for (int i = 0; i < 2; i++) begin
            n_term[i] = 0; n_pkten[i] = 0; n_err[i] = 0; n_bend[i] = 0;
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic drive(input bit [1:0] lp, input logic [31:0] d, input bit rst);
        reset = rst;
        lp_p  = lp[1];
        lp_n  = lp[0];
        hs    = d;
        model_step(rst, lp, d);
    endtask

    task automatic cyc(input bit [1:0] lp, input logic [31:0] d, input bit rst);
        @(negedge core_clk);
        model_check();
        tally();
        drive(lp, d, rst);
    endtask

    task automatic rep(input bit [1:0] lp, input int n);
        repeat (n) cyc(lp, 32'h0, 1'b0);
    endtask

    function automatic logic [31:0] nob8();
        logic [31:0] v;
        v = $urandom;
        for (int l = 0; l < 4; l++) if (v[8*l +: 8] == 8'hB8) v[8*l +: 8] = 8'h00;
        return v;
    endfunction

    // Full request; LP-11 is raised two words before the end so that the filter delay
    // lets exactly nwords data words through.
    task automatic burst(input logic [31:0] syncw, input int nwords);
        rep(L11, 4);
        rep(L01, 3);
        rep(L00, 3 + TSETTLE);
        cyc(L00, syncw, 1'b0);
        for (int w = 0; w < nwords; w++) cyc((w >= nwords - 2) ? L11 : L00, $urandom, 1'b0);
        rep(L11, 6);
    endtask

    typedef struct {
        bit [1:0]    lp;
        logic [31:0] d;
        bit          term;
        bit          pkten;
        logic [31:0] pkt;
        bit          err;
        bit          bend;
    } vec_t;

    vec_t tbl[22];

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Nominal 2-lane burst, cycle by cycle: LP01 at 4..6, LP00 at 7..16, sync at 16,
        // words at 17/18 (LP-11 already raised), output words visible at 18/19.
        for (int k = 0; k < 22; k++) begin
            tbl[k].lp    = (k < 4) ? L11 : (k < 7) ? L01 : (k < 17) ? L00 : L11;
            tbl[k].d     = (k == 16) ? 32'h0000_B8B8 : (k == 17) ? 32'h0000_2211 :
                           (k == 18) ? 32'h0000_4433 : 32'h0;
            tbl[k].term  = (k >= 10) && (k <= 19);
            tbl[k].pkten = (k == 18) || (k == 19);
            tbl[k].pkt   = (k == 18) ? 32'h0000_2211 : (k >= 19) ? 32'h0000_4433 : 32'h0;
            tbl[k].err   = 1'b0;
            tbl[k].bend  = (k == 20);
        end

        cyc(L11, 32'h0, 1'b1);
        cyc(L11, 32'h0, 1'b1);
        @(negedge core_clk);
        chk("reset_outs2", int'({term2, pkten2, err2, bend2}), 0);
        chk("reset_pkt4", int'(pkt4 != 32'h0), 0);
        drive(L11, 32'h0, 1'b0);

        clear_tally();
        for (int k = 0; k < 22; k++) begin
            @(negedge core_clk);
            model_check();
            tally();
            checks++;
            if ({term2, pkten2, err2, bend2, pkt2} !== {tbl[k].term, tbl[k].pkten, tbl[k].err, tbl[k].bend, tbl[k].pkt}) begin
                errors++;
                $display("FAIL vec%0d got term/en/err/end/pkt=%b%b%b%b/%h exp=%b%b%b%b/%h", k,
                         term2, pkten2, err2, bend2, pkt2,
                         tbl[k].term, tbl[k].pkten, tbl[k].err, tbl[k].bend, tbl[k].pkt);
            end
            drive(tbl[k].lp, tbl[k].d, 1'b0);
        end
        chk("nominal_pkten_cycles", n_pkten[0], 2);
        chk("nominal_burst_end", n_bend[0], 1);

        clear_tally();
        rep(L11, 4);
        cyc(L01, 32'h0, 1'b0);
        rep(L11, 6);
        chk("glitch_activity2", n_term[0] + n_pkten[0] + n_err[0] + n_bend[0], 0);
        chk("glitch_activity4", n_term[1] + n_pkten[1] + n_err[1] + n_bend[1], 0);

        clear_tally();
        rep(L01, 3);
        rep(L11, 6);
        chk("abort_sot_err", n_err[0] + n_err[1], 0);
        chk("abort_term", n_term[0] + n_term[1], 0);

        clear_tally();
        rep(L11, 2);
        rep(L01, 3);
        rep(L00, 3 + TSETTLE);
        rep(L00, TMO);
        repeat (4) cyc(L00, 32'hB8B8_B8B8, 1'b0);
        rep(L11, 4);
        chk("timeout_err2", n_err[0], 1);
        chk("timeout_err4", n_err[1], 1);
        chk("timeout_pkten", n_pkten[0] + n_pkten[1], 0);
        clear_tally();
        burst(32'hB8B8_B8B8, 3);
        chk("after_timeout_pkten4", n_pkten[1], 3);
        chk("after_timeout_end4", n_bend[1], 1);

        clear_tally();
        burst(32'h00B8_B8B8, 3);
        chk("partial_err4", n_err[1], 1);
        chk("partial_pkten4", n_pkten[1], 0);
        chk("partial_lanes2_pkten", n_pkten[0], 3);
        chk("partial_only_one_pulse4", n_bend[1], 0);
        clear_tally();
        burst(32'hB8B8_B8B8, 4);
        chk("partial_retry_pkten4", n_pkten[1], 4);
        chk("partial_retry_end4", n_bend[1], 1);
        chk("partial_retry_err4", n_err[1], 0);

        rep(L11, 4);
        rep(L01, 3);
        rep(L00, 3 + TSETTLE);
        cyc(L00, 32'hB8B8_B8B8, 1'b0);
        cyc(L00, $urandom, 1'b0);
        cyc(L00, $urandom, 1'b0);
        cyc(L00, $urandom, 1'b1);
        cyc(L11, 32'h0, 1'b0);
        chk("midreset_outs2", int'({term2, pkten2, err2, bend2}), 0);
        chk("midreset_outs4", int'({term4, pkten4, err4, bend4}), 0);
        clear_tally();
        rep(L11, 6);
        chk("midreset_no_end", n_bend[0] + n_bend[1] + n_err[0] + n_err[1], 0);
        clear_tally();
        burst(32'hB8B8_B8B8, 2);
        chk("midreset_fresh_pkten", n_pkten[1], 2);

        for (int it = 0; it < 30; it++) begin
            int kind;
            rep(L11, $urandom_range(2, 5));
            if ($urandom_range(0, 3) == 0) begin
                cyc(L01, 32'h0, 1'b0);
                rep(L11, 3);
            end
            rep(L01, $urandom_range(2, 4));
            kind = $urandom_range(0, 7);
            if (kind == 0) begin
                rep(L11, 4);
            end else if (kind == 1) begin
                rep(L10, 3);
                rep(L11, 4);
            end else begin
                int          guard;
                int          n;
                int          s;
                logic [31:0] syncw;
                rep(L00, 2);
                guard = 0;
                while (ph[1] != M_SYNC && guard < 20) begin
                    cyc(L00, nob8(), 1'b0);
                    guard++;
                end
                repeat ($urandom_range(0, 18)) cyc(L00, nob8(), 1'b0);
                s = $urandom_range(0, 3);
                syncw = (s < 2) ? 32'hB8B8_B8B8 : (s == 2) ? 32'h00B8_B8B8 : {nob8()};
                if (s == 3) syncw[7:0] = 8'hB8;
                cyc(L00, syncw, 1'b0);
                n = $urandom_range(0, 6);
                for (int w = 0; w < n; w++)
                    cyc((w >= n - 2) ? L11 : L00, $urandom, ($urandom_range(0, 9) == 0));
                rep(L11, 5);
            end
        end

        rep(L11, 2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
